// File: rtl/fila_pkg.sv
// Shared types and default sizing for the fila drain controller.
// Defaults describe the 8-byte queue fed by the deserializer.
package fila_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StWait,
      StPresent,
      StGap
   } fila_state_t;

   localparam int unsigned FILA_DEPTH = 8;
   localparam int unsigned FILA_HI_WM = 6;
   localparam int unsigned FILA_LO_WM = 2;

endpackage

// File: rtl/hold_hyst.sv
// Registered watermark comparator with hysteresis.
// Produces the hold/backpressure signal toward the deserializer.
module hold_hyst
   import fila_pkg::*;
#(
   parameter int unsigned LEN_W = 4,
   parameter int unsigned HI_WM = FILA_HI_WM,
   parameter int unsigned LO_WM = FILA_LO_WM
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [LEN_W-1:0] q_len_i,
   output logic             hold_o
);

   localparam logic [LEN_W-1:0] HiWm = LEN_W'(HI_WM);
   localparam logic [LEN_W-1:0] LoWm = LEN_W'(LO_WM);

   logic hold_q;
   logic hold_d;

   // Between the watermarks the previous decision is kept.
   always_comb begin
      hold_d = hold_q;
      if (q_len_i >= HiWm) begin
         hold_d = 1'b1;
      end else if (q_len_i <= LoWm) begin
         hold_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign hold_o = hold_q;

endmodule

// File: rtl/fila_ctrl.sv
// Drain controller for the fila byte queue: pops one byte at a time, presents it on a
// valid/ready port, counts deliveries and flags enqueue-while-full overflows.
module fila_ctrl
   import fila_pkg::*;
#(
   parameter int unsigned DEPTH    = FILA_DEPTH,
   parameter int unsigned LEN_W    = 4,
   parameter int unsigned HI_WM    = FILA_HI_WM,
   parameter int unsigned LO_WM    = FILA_LO_WM,
   parameter int unsigned DATA_LAT = 1,
   parameter int unsigned POP_GAP  = 0
) (
   input  logic             clk_10KHz,
   input  logic             reset,
   input  logic             enable,
   input  logic [LEN_W-1:0] q_len,
   input  logic [7:0]       q_data,
   input  logic             q_enqueue,
   output logic             q_dequeue,
   output logic             hold_out,
   output logic             m_valid,
   output logic [7:0]       m_data,
   input  logic             m_ready,
   output logic [7:0]       pop_count,
   output logic             overflow_err
);

   localparam int unsigned WaitW = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;
   localparam int unsigned GapW  = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;

   // Counters run down to zero, so they are loaded with length minus one.
   localparam logic [WaitW-1:0] WaitLoad = WaitW'(DATA_LAT - 1);
   localparam logic [GapW-1:0]  GapLoad  = GapW'((POP_GAP > 0) ? POP_GAP - 1 : 0);
   localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);
   localparam logic [GapW-1:0]  GapOne   = GapW'(1);
   localparam logic [LEN_W-1:0] FullLen  = LEN_W'(DEPTH);

   fila_state_t      state_q, state_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
   logic             m_valid_q, m_valid_d;
   logic [7:0]       m_data_q, m_data_d;
   logic [7:0]       pop_count_q, pop_count_d;
   logic             overflow_q, overflow_d;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      pop_count_d = pop_count_q;

      unique case (state_q)
         StIdle: begin
            if (enable && (q_len != '0)) begin
               state_d = StPop;
            end
         end

         StPop: begin
            state_d    = StWait;
            wait_cnt_d = WaitLoad;
         end

         StWait: begin
            if (wait_cnt_q == '0) begin
               m_data_d  = q_data;
               m_valid_d = 1'b1;
               state_d   = StPresent;
            end else begin
               wait_cnt_d = wait_cnt_q - WaitOne;
            end
         end

         StPresent: begin
            if (m_ready) begin
               m_valid_d   = 1'b0;
               pop_count_d = pop_count_q + 8'd1;
               if (POP_GAP > 0) begin
                  state_d   = StGap;
                  gap_cnt_d = GapLoad;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         StGap: begin
            if (gap_cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q - GapOne;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Sticky: only reset clears an overflow.
   always_comb begin
      overflow_d = overflow_q;
      if (q_enqueue && (q_len == FullLen)) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_10KHz or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         wait_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= 8'h00;
         pop_count_q <= 8'h00;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         pop_count_q <= pop_count_d;
         overflow_q  <= overflow_d;
      end
   end

   hold_hyst #(
      .LEN_W (LEN_W),
      .HI_WM (HI_WM),
      .LO_WM (LO_WM)
   ) u_hold_hyst (
      .clk_i   (clk_10KHz),
      .rst_ni  (reset),
      .q_len_i (q_len),
      .hold_o  (hold_out)
   );

   assign q_dequeue    = (state_q == StPop);
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign pop_count    = pop_count_q;
   assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fila_ctrl.sv
// Directed bench for fila_ctrl: a default instance plus a POP_GAP=3 instance on shared inputs.
module tb_fila_ctrl;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [3:0] q_len;
   logic [7:0] q_data;
   logic       q_enqueue;
   logic       m_ready;

   logic       q_dequeue, hold_out, m_valid, overflow_err;
   logic [7:0] m_data, pop_count;
   logic       g_q_dequeue, g_hold_out, g_m_valid, g_overflow_err;
   logic [7:0] g_m_data, g_pop_count;

   int n_tests = 0;
   int n_fail  = 0;

   fila_ctrl u_dut (
      .clk_10KHz    (clk),
      .reset        (reset),
      .enable       (enable),
      .q_len        (q_len),
      .q_data       (q_data),
      .q_enqueue    (q_enqueue),
      .q_dequeue    (q_dequeue),
      .hold_out     (hold_out),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .pop_count    (pop_count),
      .overflow_err (overflow_err)
   );

   fila_ctrl #(
      .POP_GAP (3)
   ) u_gap (
      .clk_10KHz    (clk),
      .reset        (reset),
      .enable       (enable),
      .q_len        (q_len),
      .q_data       (q_data),
      .q_enqueue    (q_enqueue),
      .q_dequeue    (g_q_dequeue),
      .hold_out     (g_hold_out),
      .m_valid      (g_m_valid),
      .m_data       (g_m_data),
      .m_ready      (m_ready),
      .pop_count    (g_pop_count),
      .overflow_err (g_overflow_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int unsigned ramp [15];
      bit          hexp [15];
      int          c, xd, dd, xg, dg, n;

      ramp = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
      hexp = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};

      reset = 1'b0; enable = 1'b0; q_len = 4'd0; q_data = 8'h00;
      q_enqueue = 1'b0; m_ready = 1'b0;
      #3;
      check_eq("rst_deq",   {31'd0, q_dequeue},    0);
      check_eq("rst_valid", {31'd0, m_valid},      0);
      check_eq("rst_hold",  {31'd0, hold_out},     0);
      check_eq("rst_ovf",   {31'd0, overflow_err}, 0);
      check_eq("rst_data",  {24'd0, m_data},       0);
      check_eq("rst_cnt",   {24'd0, pop_count},    0);
      tick();
      reset = 1'b1;

      // Single byte with default latency.
      q_len = 4'd1; q_data = 8'hA5; enable = 1'b1; m_ready = 1'b1;
      tick();
      check_eq("sb_deq_c1", {31'd0, q_dequeue}, 1);
      enable = 1'b0; q_len = 4'd0;
      tick();
      check_eq("sb_deq_c2",   {31'd0, q_dequeue}, 0);
      check_eq("sb_valid_c2", {31'd0, m_valid},   0);
      tick();
      check_eq("sb_valid_c3", {31'd0, m_valid},   1);
      check_eq("sb_data_c3",  {24'd0, m_data},    32'hA5);
      check_eq("sb_cnt_c3",   {24'd0, pop_count}, 0);
      tick();
      check_eq("sb_valid_c4", {31'd0, m_valid},   0);
      check_eq("sb_cnt_c4",   {24'd0, pop_count}, 1);
      idle(5);

      // Backpressure: consumer stalls for 5 cycles.
      m_ready = 1'b0; enable = 1'b1; q_len = 4'd2; q_data = 8'h3C;
      tick();
      check_eq("bp_deq_c1", {31'd0, q_dequeue}, 1);
      enable = 1'b0;
      idle(2);
      check_eq("bp_valid_c3", {31'd0, m_valid}, 1);
      q_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("bp_stall_valid", {31'd0, m_valid},   1);
         check_eq("bp_stall_data",  {24'd0, m_data},    32'h3C);
         check_eq("bp_stall_deq",   {31'd0, q_dequeue}, 0);
      end
      m_ready = 1'b1;
      tick();
      check_eq("bp_xfer_valid", {31'd0, m_valid},   0);
      check_eq("bp_xfer_cnt",   {24'd0, pop_count}, 2);
      idle(5);

      // Enable dropped while in WAIT.
      enable = 1'b1; q_len = 4'd3; q_data = 8'h5A;
      idle(2);
      enable = 1'b0;
      tick();
      check_eq("en_valid", {31'd0, m_valid}, 1);
      check_eq("en_data",  {24'd0, m_data},  32'h5A);
      tick();
      check_eq("en_cnt", {24'd0, pop_count}, 3);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_eq("en_no_pop", {31'd0, q_dequeue}, 0);
      end

      // Transfer-to-next-pop spacing, both instances.
      enable = 1'b1; q_len = 4'd4;
      c = 0; xd = -1; dd = -1; xg = -1; dg = -1;
      while ((dd < 0 || dg < 0) && c < 40) begin
         tick();
         c++;
         if (xd >= 0 && dd < 0 && q_dequeue) dd = c;
         if (xd < 0 && m_valid && m_ready) xd = c;
         if (xg >= 0 && dg < 0 && g_q_dequeue) dg = c;
         if (xg < 0 && g_m_valid && m_ready) xg = c;
      end
      check_eq("gap0_spacing", (dd < 0) ? 32'd999 : 32'(dd - xd), 2);
      check_eq("gap3_spacing", (dg < 0) ? 32'd999 : 32'(dg - xg), 5);
      enable = 1'b0; q_len = 4'd0;
      idle(10);

      // Hysteresis ramp.
      for (int i = 0; i < 15; i++) begin
         q_len = 4'(ramp[i]);
         tick();
         check_eq($sformatf("hyst_len%0d_step%0d", ramp[i], i), {31'd0, hold_out},
                  {31'd0, hexp[i]});
      end

      // Overflow.
      check_eq("ovf_init", {31'd0, overflow_err}, 0);
      q_len = 4'd7; q_enqueue = 1'b1;
      tick();
      check_eq("ovf_len7", {31'd0, overflow_err}, 0);
      q_len = 4'd8; q_enqueue = 1'b0;
      tick();
      check_eq("ovf_full_noenq", {31'd0, overflow_err}, 0);
      q_enqueue = 1'b1;
      tick();
      check_eq("ovf_set", {31'd0, overflow_err}, 1);
      q_enqueue = 1'b0; q_len = 4'd0;
      idle(3);
      check_eq("ovf_sticky", {31'd0, overflow_err}, 1);

      // Reset in PRESENT.
      enable = 1'b1; q_len = 4'd7; q_data = 8'hC3; m_ready = 1'b0;
      tick();
      enable = 1'b0;
      idle(2);
      check_eq("rm_valid_pre", {31'd0, m_valid},  1);
      check_eq("rm_hold_pre",  {31'd0, hold_out}, 1);
      #2;
      reset = 1'b0;
      #1;
      check_eq("rm_deq",   {31'd0, q_dequeue},    0);
      check_eq("rm_valid", {31'd0, m_valid},      0);
      check_eq("rm_data",  {24'd0, m_data},       0);
      check_eq("rm_hold",  {31'd0, hold_out},     0);
      check_eq("rm_cnt",   {24'd0, pop_count},    0);
      check_eq("rm_ovf",   {31'd0, overflow_err}, 0);
      q_len = 4'd0; m_ready = 1'b1;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("rm_no_replay", {30'd0, q_dequeue, m_valid}, 0);
      end

      // pop_count wrap after 256 deliveries.
      enable = 1'b1; q_len = 4'd1; m_ready = 1'b1;
      n = 0;
      while (pop_count != 8'd255 && n < 1200) begin
         tick();
         n++;
      end
      check_eq("wrap_255_cnt",    {24'd0, pop_count}, 255);
      check_eq("wrap_255_cycles", 32'(n), 1020);
      n = 0;
      while (pop_count == 8'd255 && n < 20) begin
         tick();
         n++;
      end
      check_eq("wrap_0_cnt",    {24'd0, pop_count}, 0);
      check_eq("wrap_0_cycles", 32'(n), 4);
      enable = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fila_ctrl.md
# fila_ctrl

Drain controller and flow-control scheduler for the byte queue (`fila`) fed by the deserializer. It runs in the queue clock domain and watches queue occupancy. It issues single-cycle dequeue pulses, captures the dequeued byte and presents it to a downstream consumer over a valid/ready handshake. It also drives a hysteretic hold signal back to the deserializer so the queue never overflows.

## Interface
Parameters:
- `DEPTH`, 8: queue capacity in bytes.
- `LEN_W`, 4: width of the occupancy input; it must represent 0..`DEPTH`.
- `HI_WM`, 6: occupancy at or above which hold asserts.
- `LO_WM`, 2: occupancy at or below which hold releases. Requires `LO_WM` < `HI_WM` ≤ `DEPTH`.
- `DATA_LAT`, 1: cycles from a dequeue pulse to valid queue output data. Must be ≥1.
- `POP_GAP`, 0: minimum idle cycles after a completed transfer before the next pop.

Ports:
- `clk_10KHz`, in, 1: sole clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: drain enable; sampled only in IDLE.
- `q_len`, in, `LEN_W`: queue occupancy.
- `q_data`, in, 8: queue data output.
- `q_enqueue`, in, 1: monitor of the queue's enqueue strobe.
- `q_dequeue`, out, 1: one-cycle dequeue pulse to the queue.
- `hold_out`, out, 1: backpressure to the deserializer; 1 means stop writing.
- `m_valid`, out, 1: output byte valid.
- `m_data`, out, 8: output byte.
- `m_ready`, in, 1: consumer accepts the byte.
- `pop_count`, out, 8: bytes delivered; wraps from 255 to 0.
- `overflow_err`, out, 1: sticky overflow flag.

## Operation
- **FSM states:** IDLE, POP, WAIT, PRESENT, GAP.
- **IDLE:** if `enable`=1 and `q_len`≠0, go to POP. Otherwise stay.
- **POP:** lasts exactly one cycle with `q_dequeue`=1, then WAIT. `q_dequeue` is 0 in every other state.
- **WAIT:** lasts `DATA_LAT` cycles, counted by a down-counter. On the edge leaving WAIT: `m_data`←`q_data`, `m_valid`←1, next state PRESENT.
- **PRESENT:** `m_valid`=1 and `m_data` stays stable until the consumer accepts.
  - On an edge with `m_ready`=1: `m_valid`←0 and `pop_count`←`pop_count`+1 (mod 256).
  - Next state is GAP if `POP_GAP`>0, else IDLE.
- **GAP:** lasts `POP_GAP` cycles, then IDLE.
- **Deasserting `enable`:** has no effect outside IDLE. An in-flight byte always completes.
- **hold_out:** registered with hysteresis.
  - Next value 1 if `q_len` ≥ `HI_WM`.
  - Next value 0 if `q_len` ≤ `LO_WM`.
  - Otherwise holds its value.
- **overflow_err:** set on any edge where `q_enqueue`=1 and `q_len`=`DEPTH`. Cleared only by reset.
- **Width rules:** occupancy comparisons are unsigned at `LEN_W` bits. `pop_count` wraps silently.

## Timing
- **Reset (`reset`=0):** asynchronous. State forced to IDLE, and `q_dequeue`, `m_valid`, `m_data`, `hold_out`, `pop_count`, `overflow_err` are all 0. Wait and gap counters are cleared.
- **Reset mid-operation:** the in-flight byte is discarded. Once the queue has been popped, that byte is not replayed.
- **Latency:** IDLE sees `enable`=1 and `q_len`>0 at edge 0. Then:
  - `q_dequeue`=1 during cycle 1.
  - `m_valid`=1 from cycle 2+`DATA_LAT`.
  - With defaults, `m_valid` rises in cycle 3.
- **Throughput:** with `m_ready` held at 1 and defaults, one byte per 4 cycles.
- **Handshake:** a transfer occurs on an edge with `m_valid`=1 and `m_ready`=1. `m_ready` may be high before `m_valid`. `m_valid` never drops without a transfer.
- **Empty queue:** no pop is issued while `q_len`=0. IDLE re-evaluates `q_len` every cycle.
- **Full queue:** pops continue normally. `hold_out` is already 1 once `q_len` ≥ `HI_WM`.
- **Simultaneous enqueue and dequeue:** no special handling. The controller trusts `q_len`.
- **hold_out latency:** one cycle after the `q_len` threshold crossing.

## Structure
- Shared package `fila_pkg` holds:
  - `fila_state_t`, the enum for IDLE/POP/WAIT/PRESENT/GAP;
  - default constants `FILA_DEPTH`, `FILA_HI_WM` and `FILA_LO_WM`.
- One sub-module, `hold_hyst`: the registered watermark comparator producing `hold_out`, parameterised by `LEN_W`, `HI_WM` and `LO_WM`.
- The FSM, counters and output register stay in `fila_ctrl`.

## Test plan
- **Single byte, defaults:** reset, then `q_len`=1, `q_data`=8'hA5, `enable`=1, `m_ready`=1 → `q_dequeue` pulses in cycle 1, `m_valid` with `m_data`=8'hA5 in cycle 3, `pop_count`=1 in cycle 4.
- **Backpressure:** `m_ready`=0 for 5 cycles after `m_valid` rises → `m_data` stable, no second `q_dequeue`. On raising `m_ready`, the transfer happens in 1 cycle.
- **Hysteresis:** ramp `q_len` 0→7→0 → `hold_out` rises the cycle after `q_len`=6, stays 1 at `q_len`=3, falls the cycle after `q_len`=2.
- **Overflow:** `q_len`=8 with `q_enqueue`=1 for one cycle → `overflow_err`=1, and it stays 1 until reset.
- **Enable and gap:**
  - Drop `enable` while in WAIT → the byte still delivered; no further pops.
  - With `POP_GAP`=3, measure transfer-to-next-`q_dequeue` spacing → 5 cycles.
- **Reset mid-operation:** assert `reset` while in PRESENT → all outputs 0 immediately. `pop_count` reaches 255 and then wraps to 0 after 256 deliveries.
